// File: rtl/spio_hss_multiplexer_cc_inserter_pkg.sv
// ============================================================================
// Module : spio_hss_multiplexer_cc_inserter_pkg
// Brief  : Shared word widths, IDLE/CC symbols and FSM encodings.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spio_hss_multiplexer_cc_inserter_pkg;

    localparam int FRM_BITS = 32;
    localparam int KCH_BITS = 4;
    localparam int CNT_BITS = 16;

    // K28.5 comma in byte 0 keeps the receiver word-aligned between frames.
    localparam logic [FRM_BITS-1:0] IDLE_DATA = 32'h5050_50BC;
    localparam logic [KCH_BITS-1:0] IDLE_KCHR = 4'b0001;
    localparam logic [FRM_BITS-1:0] CC_DATA   = 32'h1C1C_1C1C;
    localparam logic [KCH_BITS-1:0] CC_KCHR   = 4'b1111;

    typedef enum logic [1:0] {
        WAIT  = 2'd0,
        ALIGN = 2'd1,
        RUN   = 2'd2
    } hss_state_e;

endpackage

`default_nettype wire

// File: rtl/spio_hss_multiplexer_cc_timer.sv
// ============================================================================
// Module : spio_hss_multiplexer_cc_timer
// Brief  : CC period counter, CC slot decode and period-aligned cc_dis sampling.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spio_hss_multiplexer_cc_timer
    import spio_hss_multiplexer_cc_inserter_pkg::*;
#(
    parameter int CC_PERIOD = 5000,
    parameter int CC_LEN    = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic start,
    input  logic cc_dis,
    output logic cc_slot
);

    localparam logic [CNT_BITS-1:0] c_last     = CNT_BITS'(CC_PERIOD - 1);
    localparam logic [CNT_BITS-1:0] c_cc_start = CNT_BITS'(CC_PERIOD - CC_LEN);

    logic [CNT_BITS-1:0] r_cnt;
    logic                r_cc_dis_q;

    always_ff @(posedge clk) begin
        if (rst || !run) begin
            r_cnt <= '0;
        end else if (r_cnt == c_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Sampling only at the period boundary keeps a CC burst whole.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cc_dis_q <= 1'b0;
        end else if (start || (run && (r_cnt == '0))) begin
            r_cc_dis_q <= cc_dis;
        end
    end

    assign cc_slot = (r_cnt >= c_cc_start) && !r_cc_dis_q;

endmodule

`default_nettype wire

// File: rtl/spio_hss_multiplexer_cc_inserter.sv
// ============================================================================
// Module : spio_hss_multiplexer_cc_inserter
// Brief  : Muxes frame words, IDLE and periodic CC words onto the HSS TX port.
//          HSS_CC_STATS_EN builds the reg_ccnt CC-sequence counter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spio_hss_multiplexer_cc_inserter
    import spio_hss_multiplexer_cc_inserter_pkg::*;
#(
    parameter int CC_PERIOD = 5000,
    parameter int CC_LEN    = 2,
    parameter int ALIGN_LEN = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [FRM_BITS-1:0] hsl_data,
    input  logic [KCH_BITS-1:0] hsl_kchr,
    input  logic                hsl_vld,
    output logic                hsl_rdy,
    input  logic                tx_rdy,
    input  logic                cc_dis,
    output logic [FRM_BITS-1:0] tx_data,
    output logic [KCH_BITS-1:0] tx_kchr,
    output logic [15:0]         reg_ccnt
);

    localparam logic [7:0] c_align_last = 8'(ALIGN_LEN - 1);

    hss_state_e          r_state;
    hss_state_e          w_state_nxt;
    logic [7:0]          r_align_cnt;
    logic [7:0]          w_align_nxt;
    logic                w_run;
    logic                w_start;
    logic                w_cc_slot;
    logic [FRM_BITS-1:0] w_tx_data_nxt;
    logic [KCH_BITS-1:0] w_tx_kchr_nxt;

    assign w_run   = (r_state == RUN) && tx_rdy;
    assign w_start = (r_state == ALIGN) && (r_align_cnt == c_align_last) && tx_rdy;

    spio_hss_multiplexer_cc_timer #(
        .CC_PERIOD (CC_PERIOD),
        .CC_LEN    (CC_LEN)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .run     (w_run),
        .start   (w_start),
        .cc_dis  (cc_dis),
        .cc_slot (w_cc_slot)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= WAIT;
            r_align_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_align_cnt <= w_align_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_align_nxt = '0;
        case (r_state)
            WAIT: begin
                if (tx_rdy) w_state_nxt = ALIGN;
            end
            ALIGN: begin
                if (r_align_cnt == c_align_last) begin
                    w_state_nxt = RUN;
                end else begin
                    w_align_nxt = r_align_cnt + 1'b1;
                end
            end
            RUN:     w_state_nxt = RUN;
            default: w_state_nxt = WAIT;
        endcase
        // Link loss overrides everything and restarts alignment.
        if (!tx_rdy) begin
            w_state_nxt = WAIT;
            w_align_nxt = '0;
        end
    end

    assign hsl_rdy = (r_state == RUN) && !w_cc_slot;

    // A CC burst cut by tx_rdy falling is replaced by IDLE, not finished.
    always_comb begin
        w_tx_data_nxt = IDLE_DATA;
        w_tx_kchr_nxt = IDLE_KCHR;
        if (r_state == RUN) begin
            if (w_cc_slot) begin
                if (tx_rdy) begin
                    w_tx_data_nxt = CC_DATA;
                    w_tx_kchr_nxt = CC_KCHR;
                end
            end else if (hsl_vld && hsl_rdy) begin
                w_tx_data_nxt = hsl_data;
                w_tx_kchr_nxt = hsl_kchr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_data <= IDLE_DATA;
            tx_kchr <= IDLE_KCHR;
        end else begin
            tx_data <= w_tx_data_nxt;
            tx_kchr <= w_tx_kchr_nxt;
        end
    end

`ifdef HSS_CC_STATS_EN
    logic        r_cc_emit_q;
    logic [15:0] r_ccnt;
    logic        w_cc_emit;

    // CC slots of one period are contiguous, so a rising emit edge marks its first word.
    assign w_cc_emit = w_run && w_cc_slot;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cc_emit_q <= 1'b0;
            r_ccnt      <= '0;
        end else begin
            r_cc_emit_q <= w_cc_emit;
            if (w_cc_emit && !r_cc_emit_q && (r_ccnt != 16'hFFFF)) begin
                r_ccnt <= r_ccnt + 1'b1;
            end
        end
    end

    assign reg_ccnt = r_ccnt;
`else
    assign reg_ccnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_spio_hss_multiplexer_cc_inserter.sv
// ============================================================================
// Module : tb_spio_hss_multiplexer_cc_inserter
// Brief  : Directed self-checking bench for the HSS CC inserter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spio_hss_multiplexer_cc_inserter;
    import spio_hss_multiplexer_cc_inserter_pkg::*;

    localparam int CC_P = 20;
    localparam int CC_L = 2;
    localparam int AL   = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] hsl_data;
    logic [3:0]  hsl_kchr;
    logic        hsl_vld;
    logic        hsl_rdy;
    logic        tx_rdy;
    logic        cc_dis;
    logic [31:0] tx_data;
    logic [3:0]  tx_kchr;
    logic [15:0] reg_ccnt;

    always #5 clk = ~clk;

    spio_hss_multiplexer_cc_inserter #(
        .CC_PERIOD (CC_P),
        .CC_LEN    (CC_L),
        .ALIGN_LEN (AL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .hsl_data (hsl_data),
        .hsl_kchr (hsl_kchr),
        .hsl_vld  (hsl_vld),
        .hsl_rdy  (hsl_rdy),
        .tx_rdy   (tx_rdy),
        .cc_dis   (cc_dis),
        .tx_data  (tx_data),
        .tx_kchr  (tx_kchr),
        .reg_ccnt (reg_ccnt)
    );

    int          n_chk  = 0;
    int          n_fail = 0;
    int          n_word = 0;
    int          m_cnt  = 0;
    int          m_ccnt = 0;
    logic        m_dq   = 1'b0;
    logic [31:0] exp_data = 32'h5050_50BC;
    logic [3:0]  exp_kchr = 4'b0001;

    function automatic logic [31:0] dw(input int i);
        return 32'hDA7A_0000 | 32'(i);
    endfunction

    function automatic logic [3:0] kw(input int i);
        return 4'(i);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_data"}, tx_data, 32'h5050_50BC);
        chk({tag, "_kchr"}, 32'(tx_kchr), 32'h1);
        chk({tag, "_rdy"}, 32'(hsl_rdy), 32'h0);
    endtask

    // One RUN cycle with hsl_vld held high; the model tracks the period position.
    task automatic step();
        logic rdy_e;
        @(negedge clk);
        hsl_data = dw(n_word);
        hsl_kchr = kw(n_word);
        rdy_e = !((m_cnt >= CC_P - CC_L) && !m_dq);
        chk("run_rdy", 32'(hsl_rdy), 32'(rdy_e));
        chk("run_data", tx_data, exp_data);
        chk("run_kchr", 32'(tx_kchr), 32'(exp_kchr));
        if (rdy_e) begin
            exp_data = dw(n_word);
            exp_kchr = kw(n_word);
            n_word++;
        end else begin
            exp_data = 32'h1C1C_1C1C;
            exp_kchr = 4'b1111;
            if (m_cnt == CC_P - CC_L) m_ccnt++;
        end
        if (m_cnt == 0) m_dq = cc_dis;
        m_cnt = (m_cnt == CC_P - 1) ? 0 : m_cnt + 1;
    endtask

    // Called just after a negedge with hsl_data = dw(n_word) driven.
    task automatic align_seq();
        int  n_idle = 0;
        bit  got    = 0;
        tx_rdy = 1'b1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (hsl_rdy === 1'b1) begin
                got = 1;
            end else begin
                n_idle++;
                chk("align_data", tx_data, 32'h5050_50BC);
            end
        end
        chk("align_len", 32'(n_idle), 32'(AL));
        chk("align_exit_data", tx_data, 32'h5050_50BC);
        exp_data = dw(n_word);
        exp_kchr = kw(n_word);
        n_word++;
        m_dq  = cc_dis;
        m_cnt = 1;
    endtask

    initial begin
        rst      = 1'b1;
        tx_rdy   = 1'b0;
        cc_dis   = 1'b0;
        hsl_vld  = 1'b0;
        hsl_data = '0;
        hsl_kchr = '0;
        repeat (3) @(negedge clk);
        chk_idle("reset");
        chk("reset_ccnt", 32'(reg_ccnt), 32'h0);
        rst = 1'b0;

        // Link down: IDLE only, nothing accepted.
        repeat (100) begin
            @(negedge clk);
            chk_idle("wait");
        end

        // Link up with traffic pending: alignment burst, then ordered data.
        hsl_vld  = 1'b1;
        hsl_data = dw(n_word);
        hsl_kchr = kw(n_word);
        align_seq();

        // Continuous traffic across several CC periods.
        repeat (80) step();

        // cc_dis raised mid-period: current period still ends in CC.
        for (int g = 0; g < 40 && m_cnt != 5; g++) step();
        chk("ccdis_pos", 32'(m_cnt), 32'd5);
        cc_dis = 1'b1;
        for (int g = 0; g < 40 && m_cnt != 10; g++) step();
        repeat (20) step();
        for (int g = 0; g < 40 && m_cnt != 10; g++) step();
        cc_dis = 1'b0;
        repeat (50) step();

        // Link drop on the first CC slot abandons the burst.
        for (int g = 0; g < 40 && m_cnt != CC_P - CC_L; g++) step();
        @(negedge clk);
        tx_rdy   = 1'b0;
        hsl_data = dw(n_word);
        hsl_kchr = kw(n_word);
        chk("drop_rdy", 32'(hsl_rdy), 32'h0);
        chk("drop_data", tx_data, exp_data);
        @(negedge clk);
        chk_idle("drop_next");
        repeat (5) begin
            @(negedge clk);
            chk_idle("drop_wait");
        end
        align_seq();
        repeat (45) step();

        // Enough periods for the statistics counter.
        for (int g = 0; g < 400 && m_ccnt < 11; g++) step();
        step();
`ifdef HSS_CC_STATS_EN
        chk("reg_ccnt", 32'(reg_ccnt), 32'(m_ccnt));
`else
        chk("reg_ccnt", 32'(reg_ccnt), 32'h0);
`endif

        // Reset mid-traffic returns everything to reset values.
        for (int g = 0; g < 40 && m_cnt != 7; g++) step();
        rst = 1'b1;
        @(negedge clk);
        chk_idle("rst_mid");
        chk("rst_mid_ccnt", 32'(reg_ccnt), 32'h0);
        rst = 1'b0;
        hsl_data = dw(n_word);
        hsl_kchr = kw(n_word);
        align_seq();
        repeat (25) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
